// File: rtl/seq_approx_mult_if.sv
// Operand/product handshake bundle for seq_approx_mult.
// The master drives operands and consumes products; the slave is the multiplier.
interface seq_approx_mult_if #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(2*WIDTH+1)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [KW-1:0]      in_k;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;

    modport master (
        output in_valid, in_a, in_b, in_k, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, in_k, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/seq_approx_mult.sv
// Iterative shift-add multiplier whose accumulator adder treats the low K columns
// with the approximate cell (S = ~X, no carry) and the rest as an exact ripple add.
module seq_approx_mult #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(2*WIDTH+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_approx_mult_if.slave bus
);
    localparam int PW = 2*WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [KW:0]   K_MAX = PW[KW:0];
    localparam logic [CW-1:0] LAST  = CW'(WIDTH-1);

    logic [1:0]       state;
    logic             ready_flag;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [KW:0]      k_reg;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    p_reg;

    logic             accept_ok;
    logic [KW:0]      k_in;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    approx_mask;
    logic [PW-1:0]    exact_sum;
    logic [PW-1:0]    hybrid_sum;

    assign accept_ok = (state == IDLE) && ready_flag;
    assign k_in      = ({1'b0, bus.in_k} > K_MAX) ? K_MAX : {1'b0, bus.in_k};

    // Masking both operands below K' zeroes those columns, so the exact part sees
    // carry-in 0 at column K' and the approximate columns contribute no carry.
    assign addend      = {{WIDTH{1'b0}}, a_reg} << cnt;
    assign approx_mask = ~({PW{1'b1}} << k_reg);
    assign exact_sum   = (p_reg & ~approx_mask) + (addend & ~approx_mask);
    assign hybrid_sum  = (~p_reg & approx_mask) | exact_sum;

    assign bus.in_ready  = accept_ok;
    assign bus.out_valid = (state == DONE);
    assign bus.out_p     = p_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready_flag <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            k_reg      <= '0;
            cnt        <= '0;
            p_reg      <= '0;
        end else begin
            ready_flag <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.in_valid && accept_ok) begin
                        a_reg <= bus.in_a;
                        b_reg <= bus.in_b;
                        k_reg <= k_in;
                        cnt   <= '0;
                        p_reg <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (b_reg[cnt]) begin
                        p_reg <= hybrid_sum;
                    end
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
